mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request an operation, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port div_zero, output, 1 bit: high with done when a DIV/DIVU had b==0.
REQ-011 SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-012 SHALL have port lo, output, WIDTH bits: product lower half, or quotient.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL register op, a and b, load an iteration counter with WIDTH-1, and go to CALC.
  - Exception: DIV/DIVU with b==0 SHALL go directly to DONE.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle on operand magnitudes (signed ops) or raw values (unsigned ops).
  - It SHALL run exactly WIDTH cycles, decrementing the counter each cycle.
  - It SHALL go to FIX when the counter is 0.
REQ-016 FIX SHALL apply the sign correction, then go to DONE.
  - MULT: negate the 2*WIDTH product when the operand signs differ.
  - DIV: negate the quotient when the operand signs differ; give the remainder the sign of the dividend.
REQ-017 DONE SHALL assert done for exactly one cycle, load hi/lo with the result, and return to IDLE.
REQ-018 done SHALL be high exactly WIDTH+2 cycles after the edge at which start was sampled.
  - For divide-by-zero the latency SHALL be 1 cycle.
REQ-019 Multiply SHALL produce {hi,lo} equal to the full 2*WIDTH-bit exact product.
REQ-020 Divide SHALL truncate the quotient toward zero and SHALL satisfy a == lo*b + hi.
REQ-021 Signed DIV of -2^(WIDTH-1) by -1 SHALL give lo = -2^(WIDTH-1) and hi = 0, with no error flag.
REQ-022 Divide-by-zero SHALL assert div_zero with done for one cycle, and hi/lo SHALL keep their prior values.
REQ-023 start while busy SHALL be ignored; the operands registered at start are used, and later changes to a, b or op have no effect.
REQ-024 start sampled in the same cycle as the DONE state SHALL be ignored; a new operation is accepted on the next IDLE cycle at the earliest.
REQ-025 hi and lo SHALL hold their value from the last DONE until the next DONE that updates them.
REQ-026 div_zero SHALL be 0 whenever done is 0.

Reset
REQ-027 reset=1 at a rising edge SHALL, in any state including mid-CALC, force the outputs and state as follows:
  - state IDLE;
  - busy=0, done=0, div_zero=0;
  - hi=0, lo=0, counter=0.
  No done pulse SHALL follow for the aborted operation.
REQ-028 reset SHALL take priority over start in the same cycle.
REQ-029 The first start SHALL be accepted on the first edge with reset=0.

Verification (WIDTH=32)
REQ-030 The bench SHALL cover MULT a=7, b=0xFFFFFFFD (-3) -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 The bench SHALL cover MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 The bench SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 The bench SHALL cover DIVU a=100, b=0 after a prior result hi=1, lo=2 -> done and div_zero high one cycle after start; hi=1, lo=2 unchanged.
REQ-034 The bench SHALL cover reset asserted at CALC cycle 10 of a MULT -> next cycle busy=0, hi=lo=0, and no done within 40 cycles.
  - A new DIVU 9/4 started afterwards -> lo=2, hi=1.
REQ-035 The bench SHALL cover start pulsed again with different operands during busy -> exactly one done pulse, carrying the result of the first operands.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per
// cycle on operand magnitudes, followed by a sign-fix cycle and a registered result.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, state_next;
   logic               op_div_r;
   logic               a_neg_r, b_neg_r, dz_r;
   logic [WIDTH-1:0]   m_r;
   logic [2*WIDTH-1:0] p_r;
   logic [CW-1:0]      count_r;

   logic               start_signed, start_dz, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] p_step, p_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Handshake: start is only looked at in IDLE; done/div_zero are single-cycle
   // pulses that coincide with hi/lo taking the new result (busy is already low).
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_comb begin
      start_signed = ~op[0];
      start_dz     = op[1] && (b == '0);
      a_neg        = start_signed & a[WIDTH-1];
      b_neg        = start_signed & b[WIDTH-1];
      a_mag        = a_neg ? -a : a;
      b_mag        = b_neg ? -b : b;
   end

   // p_r holds {partial_hi, multiplier_bits} for multiply, {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, p_r[2*WIDTH-1:WIDTH]} +
                  (p_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
      div_trial = p_r[2*WIDTH-1:WIDTH-1] - {1'b0, m_r};
      if (op_div_r) begin
         p_step = div_trial[WIDTH] ? {p_r[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
      end else begin
         p_step = {mul_sum, p_r[WIDTH-1:1]};
      end
      quo_fix = (a_neg_r ^ b_neg_r) ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
      rem_fix = a_neg_r ? -p_r[2*WIDTH-1:WIDTH] : p_r[2*WIDTH-1:WIDTH];
      if (op_div_r) begin
         p_fix = {rem_fix, quo_fix};
      end else begin
         p_fix = (a_neg_r ^ b_neg_r) ? -p_r : p_r;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = start_dz ? DONE : CALC;
         CALC: if (count_r == '0) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_div_r <= 1'b0;
         a_neg_r  <= 1'b0;
         b_neg_r  <= 1'b0;
         dz_r     <= 1'b0;
         m_r      <= '0;
         p_r      <= '0;
         count_r  <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_div_r <= op[1];
               a_neg_r  <= a_neg;
               b_neg_r  <= b_neg;
               dz_r     <= start_dz;
               m_r      <= b_mag;
               p_r      <= {{WIDTH{1'b0}}, a_mag};
               count_r  <= CW'(WIDTH-1);
            end
            CALC: begin
               p_r <= p_step;
               if (count_r != '0) count_r <= count_r - 1'b1;
            end
            FIX:  p_r <= p_fix;
            DONE: begin
               done     <= 1'b1;
               div_zero <= dz_r;
               // A divide-by-zero leaves the previous result visible.
               if (!dz_r) {hi, lo} <= p_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32: checks results, latency, div-by-zero,
// reset abort and start-while-busy behaviour against hand-computed values.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   logic [1:0]  state_dbg;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
      .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   // Starts an operation and waits (bounded) for done; lat is -1 on timeout.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
      @(negedge clock);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got %0b want 0", div_zero); end
      n_vec++; if (hi !== 32'h0)      begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
      n_vec++; if (lo !== 32'h0)      begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
      @(negedge clock);
      op = MULT; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clock);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_priority busy got %0b want 0", busy); end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1 start = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_start busy got %0b want 1", busy); end
      for (int i = 0; i < 50; i++) begin
         @(posedge clock);
         #1;
         if (done) break;
      end
      n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL first_start lo got %h want c", lo); end
   endtask

   task automatic test_mult;
      int lat;
      run_op(MULT, 32'd7, 32'hFFFFFFFD, lat);
      n_vec++; if (lat !== 34)           begin n_err++; $display("FAIL mult_latency got %0d want 34", lat); end
      n_vec++; if (hi !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL mult_neg hi got %h want ffffffff", hi); end
      n_vec++; if (lo !== 32'hFFFFFFEB)  begin n_err++; $display("FAIL mult_neg lo got %h want ffffffeb", lo); end
      n_vec++; if (div_zero !== 1'b0)    begin n_err++; $display("FAIL mult_dz got %0b want 0", div_zero); end
      run_op(MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, lat);
      n_vec++; if (hi !== 32'h0)         begin n_err++; $display("FAIL mult_negneg hi got %h want 0", hi); end
      n_vec++; if (lo !== 32'd30)        begin n_err++; $display("FAIL mult_negneg lo got %h want 1e", lo); end
      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      n_vec++; if (hi !== 32'hFFFFFFFE)  begin n_err++; $display("FAIL multu hi got %h want fffffffe", hi); end
      n_vec++; if (lo !== 32'h00000001)  begin n_err++; $display("FAIL multu lo got %h want 1", lo); end
   endtask

   task automatic test_div;
      int lat;
      run_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
      n_vec++; if (lat !== 34)           begin n_err++; $display("FAIL div_latency got %0d want 34", lat); end
      n_vec++; if (lo !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_neg lo got %h want fffffffd", lo); end
      n_vec++; if (hi !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL div_neg hi got %h want ffffffff", hi); end
      run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
      n_vec++; if (lo !== 32'h80000000)  begin n_err++; $display("FAIL div_ovf lo got %h want 80000000", lo); end
      n_vec++; if (hi !== 32'h0)         begin n_err++; $display("FAIL div_ovf hi got %h want 0", hi); end
      n_vec++; if (div_zero !== 1'b0)    begin n_err++; $display("FAIL div_ovf dz got %0b want 0", div_zero); end
      run_op(DIV, 32'd7, 32'hFFFFFFFE, lat);
      n_vec++; if (lo !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_negdiv lo got %h want fffffffd", lo); end
      n_vec++; if (hi !== 32'd1)         begin n_err++; $display("FAIL div_negdiv hi got %h want 1", hi); end
      run_op(DIVU, 32'd100, 32'd7, lat);
      n_vec++; if (lo !== 32'd14)        begin n_err++; $display("FAIL divu lo got %h want e", lo); end
      n_vec++; if (hi !== 32'd2)         begin n_err++; $display("FAIL divu hi got %h want 2", hi); end
   endtask

   task automatic test_div_zero;
      int lat;
      run_op(DIVU, 32'd5, 32'd2, lat);
      n_vec++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_err++; $display("FAIL dz_setup hi/lo got %h/%h want 1/2", hi, lo); end
      run_op(DIVU, 32'd100, 32'd0, lat);
      n_vec++; if (lat !== 1)         begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
      n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %0b want 1", div_zero); end
      n_vec++; if (hi !== 32'd1)      begin n_err++; $display("FAIL dz_hold hi got %h want 1", hi); end
      n_vec++; if (lo !== 32'd2)      begin n_err++; $display("FAIL dz_hold lo got %h want 2", lo); end
      @(posedge clock);
      #1;
      n_vec++; if ({done, div_zero} !== 2'b00) begin n_err++; $display("FAIL dz_pulse done/dz got %b want 00", {done, div_zero}); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int n_done;
      @(negedge clock);
      op = MULT; a = 32'd1234; b = 32'd5678; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL mid_reset busy got %0b want 0", busy); end
      n_vec++; if ({hi, lo} !== 64'h0)    begin n_err++; $display("FAIL mid_reset hi/lo got %h/%h want 0/0", hi, lo); end
      @(negedge clock);
      reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (done) n_done++;
      end
      n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL mid_reset_no_done got %0d want 0", n_done); end
      run_op(DIVU, 32'd9, 32'd4, lat);
      n_vec++; if (lo !== 32'd2) begin n_err++; $display("FAIL post_reset_divu lo got %h want 2", lo); end
      n_vec++; if (hi !== 32'd1) begin n_err++; $display("FAIL post_reset_divu hi got %h want 1", hi); end
   endtask

   task automatic test_back_to_back;
      int n_done;
      int first_lat;
      logic [31:0] got_hi, got_lo;
      n_done = 0; first_lat = -1; got_hi = '0; got_lo = '0;
      @(negedge clock);
      op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clock);
         // Second start mid-CALC, third start presented while the FSM sits in DONE.
         if (i == 5 || i == 34) begin
            op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock);
         #1;
         if (done) begin
            n_done++;
            if (first_lat < 0) begin
               first_lat = i; got_hi = hi; got_lo = lo;
            end
         end
      end
      start = 1'b0;
      n_vec++; if (n_done !== 1)     begin n_err++; $display("FAIL b2b_done_count got %0d want 1", n_done); end
      n_vec++; if (first_lat !== 34) begin n_err++; $display("FAIL b2b_latency got %0d want 34", first_lat); end
      n_vec++; if ({got_hi, got_lo} !== {32'd0, 32'd42}) begin n_err++; $display("FAIL b2b_result hi/lo got %h/%h want 0/2a", got_hi, got_lo); end
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL b2b_idle busy got %0b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
